// File: rtl/exc_sequencer.sv
// Exception/eret sequencer: picks the oldest pending event, pulses the coprocessor-0 commit
// strobes, flushes the pipeline and redirects fetch to the handler or to EPC.
module exc_sequencer #(
  parameter logic [31:0] HANDLER_PC   = 32'h0000_4180,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_d,
  input  logic        exc_e,
  input  logic        exc_m,
  input  logic [4:0]  code_d,
  input  logic [4:0]  code_e,
  input  logic [4:0]  code_m,
  input  logic [31:0] pc_d,
  input  logic [31:0] pc_e,
  input  logic [31:0] pc_m,
  input  logic        bd_d,
  input  logic        bd_e,
  input  logic        bd_m,
  input  logic        valid_d,
  input  logic        valid_e,
  input  logic        valid_m,
  input  logic        int_req,
  input  logic        eret_m,
  input  logic [31:0] epc_in,
  input  logic        redirect_ack,
  output logic        cp0_exc,
  output logic [4:0]  cp0_code,
  output logic [31:0] cp0_pc,
  output logic        cp0_bd,
  output logic        cp0_exl_clr,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic [15:0] exc_count
);

  typedef enum logic [2:0] {IDLE, COMMIT, DRAIN, ERET, REDIRECT} state_t;

  // DRAIN covers FLUSH_CYCLES-1 cycles, so the counter starts at FLUSH_CYCLES-2.
  localparam logic [3:0] DRAIN_LOAD = 4'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

  state_t      state;
  logic [3:0]  drain_cnt;

  logic        sel_exc;
  logic        sel_eret;
  logic [4:0]  sel_code;
  logic [31:0] sel_pc;
  logic        sel_bd;
  logic        int_take;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    sel_exc  = 1'b0;
    sel_eret = 1'b0;
    sel_code = 5'd0;
    sel_pc   = 32'd0;
    sel_bd   = 1'b0;
    int_take = int_req && (valid_m || valid_e || valid_d);
    if (int_take) begin
      sel_exc = 1'b1;
      if (valid_m)      begin sel_pc = pc_m; sel_bd = bd_m; end
      else if (valid_e) begin sel_pc = pc_e; sel_bd = bd_e; end
      else              begin sel_pc = pc_d; sel_bd = bd_d; end
    end else if (exc_m) begin
      sel_exc = 1'b1; sel_code = code_m; sel_pc = pc_m; sel_bd = bd_m;
    end else if (exc_e) begin
      sel_exc = 1'b1; sel_code = code_e; sel_pc = pc_e; sel_bd = bd_e;
    end else if (exc_d) begin
      sel_exc = 1'b1; sel_code = code_d; sel_pc = pc_d; sel_bd = bd_d;
    end else if (eret_m) begin
      sel_eret = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      drain_cnt      <= 4'd0;
      cp0_exc        <= 1'b0;
      cp0_code       <= 5'd0;
      cp0_pc         <= 32'd0;
      cp0_bd         <= 1'b0;
      cp0_exl_clr    <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      busy           <= 1'b0;
      exc_count      <= 16'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sel_exc) begin
            state     <= COMMIT;
            cp0_exc   <= 1'b1;
            flush     <= 1'b1;
            busy      <= 1'b1;
            cp0_code  <= sel_code;
            cp0_pc    <= sel_bd ? sel_pc - 32'd4 : sel_pc;
            cp0_bd    <= sel_bd;
            exc_count <= exc_count + 16'd1;
          end else if (sel_eret) begin
            state       <= ERET;
            cp0_exl_clr <= 1'b1;
            flush       <= 1'b1;
            busy        <= 1'b1;
          end
        end
        COMMIT: begin
          cp0_exc <= 1'b0;
          if (FLUSH_CYCLES > 1) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end else begin
            state          <= REDIRECT;
            flush          <= 1'b0;
            redirect_valid <= 1'b1;
            redirect_pc    <= HANDLER_PC;
          end
        end
        DRAIN: begin
          if (drain_cnt == 4'd0) begin
            state          <= REDIRECT;
            flush          <= 1'b0;
            redirect_valid <= 1'b1;
            redirect_pc    <= HANDLER_PC;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        ERET: begin
          state          <= REDIRECT;
          cp0_exl_clr    <= 1'b0;
          flush          <= 1'b0;
          redirect_valid <= 1'b1;
          redirect_pc    <= epc_in & 32'hFFFF_FFFC;
        end
        REDIRECT: begin
          if (redirect_ack) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            busy           <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer: selection priority, victim latch, flush/redirect timing,
// eret path, redirect hold and reset abort.
module tb_exc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_d, exc_e, exc_m;
  logic [4:0]  code_d, code_e, code_m;
  logic [31:0] pc_d, pc_e, pc_m;
  logic        bd_d, bd_e, bd_m;
  logic        valid_d, valid_e, valid_m;
  logic        int_req, eret_m, redirect_ack;
  logic [31:0] epc_in;
  logic        cp0_exc, cp0_bd, cp0_exl_clr, flush, redirect_valid, busy;
  logic [4:0]  cp0_code;
  logic [31:0] cp0_pc, redirect_pc;
  logic [15:0] exc_count;

  int n_cmp = 0;
  int n_err = 0;

  exc_sequencer dut (
    .clk(clk), .reset(reset),
    .exc_d(exc_d), .exc_e(exc_e), .exc_m(exc_m),
    .code_d(code_d), .code_e(code_e), .code_m(code_m),
    .pc_d(pc_d), .pc_e(pc_e), .pc_m(pc_m),
    .bd_d(bd_d), .bd_e(bd_e), .bd_m(bd_m),
    .valid_d(valid_d), .valid_e(valid_e), .valid_m(valid_m),
    .int_req(int_req), .eret_m(eret_m), .epc_in(epc_in),
    .redirect_ack(redirect_ack),
    .cp0_exc(cp0_exc), .cp0_code(cp0_code), .cp0_pc(cp0_pc), .cp0_bd(cp0_bd),
    .cp0_exl_clr(cp0_exl_clr), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  // Outputs are sampled and inputs changed 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    {exc_d, exc_e, exc_m} = 3'b000;
    {code_d, code_e, code_m} = 15'd0;
    {pc_d, pc_e, pc_m} = 96'd0;
    {bd_d, bd_e, bd_m} = 3'b000;
    {valid_d, valid_e, valid_m} = 3'b000;
    int_req = 1'b0; eret_m = 1'b0; epc_in = 32'd0; redirect_ack = 1'b0;
  endtask

  // Wait (bounded) for redirect_valid, check the target, acknowledge and return to IDLE.
  task automatic finish_seq(input string tag, input logic [31:0] exp_pc);
    int n = 0;
    while (redirect_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_redirect_seen"}, redirect_valid, 1'b1);
    check({tag, "_redirect_pc"}, redirect_pc, exp_pc);
    redirect_ack = 1'b1;
    tick();
    redirect_ack = 1'b0;
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_exc_count", exc_count, 16'd0);
    check("rst_outs", {cp0_exc, cp0_exl_clr, flush, redirect_valid}, 4'd0);

    // Exception in M: exact timing for FLUSH_CYCLES = 2.
    exc_m = 1'b1; code_m = 5'd4; pc_m = 32'h3010; valid_m = 1'b1;
    tick();
    exc_m = 1'b0;
    check("m_cp0_exc", cp0_exc, 1'b1);
    check("m_code", cp0_code, 5'd4);
    check("m_pc", cp0_pc, 32'h3010);
    check("m_bd", cp0_bd, 1'b0);
    check("m_flush1", flush, 1'b1);
    check("m_busy", busy, 1'b1);
    tick();
    check("m_pulse_end", cp0_exc, 1'b0);
    check("m_flush2", flush, 1'b1);
    check("m_no_early_redirect", redirect_valid, 1'b0);
    tick();
    check("m_flush_off", flush, 1'b0);
    check("m_redirect_valid", redirect_valid, 1'b1);
    finish_seq("m", 32'h4180);
    check("m_count", exc_count, 16'd1);
    clear_inputs();

    // E and D together: E is older; branch-delay victim.
    exc_e = 1'b1; code_e = 5'd10; pc_e = 32'h3020; bd_e = 1'b1;
    exc_d = 1'b1; code_d = 5'd3;  pc_d = 32'h3024;
    tick();
    clear_inputs();
    check("e_cp0_exc", cp0_exc, 1'b1);
    check("e_code", cp0_code, 5'd10);
    check("e_pc", cp0_pc, 32'h301C);
    check("e_bd", cp0_bd, 1'b1);
    finish_seq("e", 32'h4180);
    check("e_count", exc_count, 16'd2);

    // Interrupt beats exc_m; target is oldest valid stage (E).
    int_req = 1'b1; valid_e = 1'b1; pc_e = 32'h3040;
    exc_m = 1'b1; code_m = 5'd4; pc_m = 32'h3010;
    tick();
    clear_inputs();
    check("int_cp0_exc", cp0_exc, 1'b1);
    check("int_code", cp0_code, 5'd0);
    check("int_pc", cp0_pc, 32'h3040);
    finish_seq("int", 32'h4180);

    // Interrupt with no valid stage waits in IDLE.
    int_req = 1'b1; pc_d = 32'h3050;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("int_wait_busy", busy, 1'b0);
    end
    valid_d = 1'b1;
    tick();
    clear_inputs();
    check("intd_cp0_exc", cp0_exc, 1'b1);
    check("intd_pc", cp0_pc, 32'h3050);
    finish_seq("intd", 32'h4180);
    check("intd_count", exc_count, 16'd4);

    // Eret: one-cycle EXL clear and flush, redirect to word-aligned EPC, count unchanged.
    eret_m = 1'b1; epc_in = 32'h3015;
    tick();
    eret_m = 1'b0;
    check("eret_exl_clr", cp0_exl_clr, 1'b1);
    check("eret_flush", flush, 1'b1);
    check("eret_no_exc", cp0_exc, 1'b0);
    tick();
    check("eret_exl_clr_end", cp0_exl_clr, 1'b0);
    check("eret_flush_end", flush, 1'b0);
    finish_seq("eret", 32'h3014);
    check("eret_count", exc_count, 16'd4);
    clear_inputs();

    // Eret together with exc_m: exception path wins.
    eret_m = 1'b1; epc_in = 32'h3015; exc_m = 1'b1; code_m = 5'd12; pc_m = 32'h3060;
    tick();
    clear_inputs();
    check("eretx_cp0_exc", cp0_exc, 1'b1);
    check("eretx_exl_clr", cp0_exl_clr, 1'b0);
    check("eretx_code", cp0_code, 5'd12);
    finish_seq("eretx", 32'h4180);
    check("eretx_count", exc_count, 16'd5);

    // Redirect held while ack stays low; a request during busy is ignored.
    exc_d = 1'b1; code_d = 5'd8; pc_d = 32'h3070;
    tick();
    exc_d = 1'b0;
    tick(); tick();
    exc_e = 1'b1; code_e = 5'd9; pc_e = 32'h3080;
    for (int i = 0; i < 4; i++) begin
      check("hold_valid", redirect_valid, 1'b1);
      check("hold_pc", redirect_pc, 32'h4180);
      check("hold_count", exc_count, 16'd6);
      tick();
    end
    redirect_ack = 1'b1;
    tick();
    redirect_ack = 1'b0;
    check("hold_idle", busy, 1'b0);
    // The still-pending E request is taken after return to IDLE.
    tick();
    exc_e = 1'b0;
    check("pending_cp0_exc", cp0_exc, 1'b1);
    check("pending_code", cp0_code, 5'd9);
    finish_seq("pending", 32'h4180);
    check("pending_count", exc_count, 16'd7);

    // Reset during DRAIN aborts the sequence.
    exc_m = 1'b1; code_m = 5'd5; pc_m = 32'h3090;
    tick();
    exc_m = 1'b0;
    tick();
    check("drain_flush", flush, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_outs", {cp0_exc, cp0_exl_clr, flush, redirect_valid, busy}, 5'd0);
    check("rst2_code_pc", {27'd0, cp0_code} | cp0_pc | redirect_pc, 32'd0);
    check("rst2_count", exc_count, 16'd0);
    tick();
    check("rst2_stay_idle", {busy, redirect_valid, cp0_exc}, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exc_sequencer.md
Name: exc_sequencer

Overview:
- Sequences entry into and return from exceptions for the pipelined CPU.
- Collects exception requests from the D, E and M stages and the coprocessor-0 interrupt request, and picks the oldest event.
- Drives the coprocessor-0 commit strobes (exception pulse, code, victim PC, branch-delay flag, EXL clear).
- Flushes the pipeline, then redirects fetch to the handler, or to EPC on eret.

Parameters:
- HANDLER_PC, 32'h0000_4180, exception/interrupt entry address.
- FLUSH_CYCLES, 2, cycles flush is held, counting the COMMIT cycle; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- exc_d / exc_e / exc_m  in  1 each  exception pending in stage D/E/M
- code_d / code_e / code_m  in  5 each  ExcCode for the stage
- pc_d / pc_e / pc_m  in  32 each  PC of the instruction in the stage
- bd_d / bd_e / bd_m  in  1 each  instruction in the stage sits in a branch-delay slot
- valid_d / valid_e / valid_m  in  1 each  stage holds a real instruction, not a bubble
- int_req  in  1  interrupt request from coprocessor 0
- eret_m  in  1  eret in the M stage
- epc_in  in  32  current EPC from coprocessor 0
- redirect_ack  in  1  fetch accepted the redirect
- cp0_exc  out  1  one-cycle exception/interrupt commit pulse
- cp0_code  out  5  ExcCode to coprocessor 0
- cp0_pc  out  32  victim PC (EPC value)
- cp0_bd  out  1  BD flag
- cp0_exl_clr  out  1  one-cycle EXL clear pulse
- flush  out  1  kill the F/D/E/M stages
- redirect_valid  out  1  redirect_pc is valid
- redirect_pc  out  32  new fetch address
- busy  out  1  sequencer not IDLE; also stalls fetch
- exc_count  out  16  committed events, wraps at 16'hFFFF->0

Behaviour:
- Reset: state IDLE; all outputs 0, including exc_count. Reset mid-sequence aborts immediately and raises no pulses.
- States: IDLE, COMMIT, DRAIN, ERET, REDIRECT.
- Event selection, done in IDLE each cycle; priority highest first:
  1. Interrupt: int_req with at least one valid stage. Target stage is the oldest valid one (M, else E, else D). code = 0.
  2. exc_m
  3. exc_e
  4. exc_d
  5. eret_m (only when exc_m = 0)
- If int_req is high but no stage is valid, stay in IDLE and re-evaluate next cycle.
- Victim latch: on selection, register code, victim PC and BD from the chosen stage.
  - bd = 1: cp0_pc = pc - 4 (modulo 2^32), cp0_bd = 1.
  - bd = 0: cp0_pc = pc, cp0_bd = 0.
- IDLE -> COMMIT on an exception or interrupt.
  - COMMIT lasts exactly 1 cycle: cp0_exc = 1, flush = 1, exc_count += 1.
- COMMIT -> DRAIN when FLUSH_CYCLES > 1, else straight to REDIRECT.
  - DRAIN holds flush = 1 for FLUSH_CYCLES - 1 cycles using a down-counter, then goes to REDIRECT.
  - redirect_pc is loaded with HANDLER_PC.
- IDLE -> ERET on an eret.
  - ERET lasts 1 cycle: cp0_exl_clr = 1, flush = 1.
  - redirect_pc = {epc_in[31:2], 2'b00}, sampled in the ERET cycle.
  - Then go to REDIRECT. exc_count is unchanged.
- REDIRECT: redirect_valid = 1 and redirect_pc held stable until redirect_ack = 1 in the same cycle, then return to IDLE. flush = 0 throughout.
- cp0_code, cp0_pc and cp0_bd stay registered and stable from COMMIT until the next selection. They are only meaningful while cp0_exc = 1.
- busy = 1 in every state except IDLE.
- While busy, all exc_*, int_req and eret_m inputs are ignored; the flush kills them. A request still present on return to IDLE is taken normally.
- Timing: request sampled at edge T; cp0_exc high in cycle T+1; redirect_valid first high in cycle T+1+FLUSH_CYCLES.

Test Plan:
- exc_m = 1, code_m = 5'd4, pc_m = 32'h3010, bd_m = 0, FLUSH_CYCLES = 2 -> next cycle cp0_exc = 1, cp0_code = 4, cp0_pc = 32'h3010, cp0_bd = 0; flush high 2 cycles; then redirect_valid = 1, redirect_pc = 32'h4180; ack -> IDLE, exc_count = 1.
- exc_e = 1 (code 10, pc 32'h3020, bd_e = 1) and exc_d = 1 together -> E chosen; cp0_pc = 32'h301C, cp0_bd = 1, cp0_code = 10.
- int_req = 1, valid_m = 0, valid_e = 1, pc_e = 32'h3040, exc_m = 1 -> interrupt wins; cp0_code = 0, cp0_pc = 32'h3040.
- int_req = 1 with all valid_* = 0 for 3 cycles, then valid_d = 1 -> stays IDLE 3 cycles, then commits with cp0_pc = pc_d.
- eret_m = 1, epc_in = 32'h3015 -> cp0_exl_clr pulse for 1 cycle, flush for 1 cycle, redirect_pc = 32'h3014, exc_count unchanged; eret_m together with exc_m -> exception path taken.
- redirect_ack held 0 for 4 cycles -> redirect_valid and redirect_pc stable; reset asserted during DRAIN -> all outputs 0 next cycle, state IDLE.
